riscv_alu: RTL and testbench
============================

Name: riscv_alu

Overview:
- 32-bit integer ALU for the RV32I execute stage.
- Computes one of twelve arithmetic, logic, shift, compare or pass operations on two operands, selected by a 4-bit opcode.
- The result is registered, so it is available to the following pipeline stage one clock later.
- Single clock domain; asynchronous active-low reset.

Parameters:
- XLEN, 32, datapath width. Only 32 is required. Shift amount is always taken from in2[4:0].

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in1  input  32  operand A (rs1 / PC)
- in2  input  32  operand B (rs2 / immediate)
- alu_op  input  4  operation select
- alu_out  output  32  registered result

Behaviour:
- Reset: while rst_n=0, alu_out=0 immediately, with no clock needed. Reset deassertion takes effect at the first posedge clk after rst_n=1.
- Latency: one cycle. The result of in1/in2/alu_op sampled at posedge N appears on alu_out after posedge N and holds until posedge N+1. A new operation is accepted every cycle; there is no handshake and no stall.
- Opcode map (result computed combinationally, then registered):
  - 0 ADD: in1+in2, modulo 2^32, carry discarded.
  - 1 SUB: in1-in2, modulo 2^32.
  - 2 AND: in1 & in2.
  - 3 OR: in1 | in2.
  - 4 XOR: in1 ^ in2.
  - 5 SLL: in1 << in2[4:0].
  - 6 SRL: in1 >> in2[4:0], zero fill.
  - 7 SLT: 1 if signed(in1) < signed(in2), else 0. Zero-extended to 32 bits.
  - 8 SLTU: 1 if unsigned(in1) < unsigned(in2), else 0. Zero-extended to 32 bits.
  - 9 PASS_B: in2 (LUI).
  - 10 PASS_A: in1.
  - 11 SRA: in1 >>> in2[4:0], sign fill from in1[31].
  - 12-15: reserved; result is 0.
- Shifts: in2[31:5] are ignored. A shift amount of 0 returns in1 unchanged.
- Overflow: not flagged. ADD and SUB simply wrap.
- X/undefined opcode: treated as reserved and yields 0. Use a full case with a default branch.
- Reset mid-operation: any result in flight is discarded and alu_out is forced to 0.

Decomposition:
- Shared package riscv_alu_pkg holds:
  - the 4-bit opcode constants ALU_ADD..ALU_SRA, with the values above;
  - the XLEN constant.
- Instantiating a separate shifter sub-module (alu_shifter) for SLL/SRL/SRA is optional. It takes in1, shamt[4:0] and a 2-bit shift type, and is purely combinational.
- The output register lives in the top module.

Test Plan:
- Reset: drive rst_n=0 asynchronously mid-cycle with alu_out holding 0x12345678 -> alu_out=0 with no clock edge. Release rst_n -> still 0 until the next posedge.
- SRA: in1=0xFFFFFFFE, in2=14, op=11 -> alu_out=0xFFFFFFFF one cycle later. Same operands with op=6 (SRL) -> 0x0003FFFF.
- Shift amount masking: in1=0x00000001, in2=0x00000021, op=5 -> 0x00000002, because only in2[4:0]=1 is used.
- Arithmetic wrap: in1=0xFFFFFFFF, in2=1, op=0 -> 0x00000000. in1=0, in2=1, op=1 -> 0xFFFFFFFF.
- Compare: in1=0xFFFFFFFE, in2=14.
  - op=7 (SLT) -> 1, since -2 < 14.
  - op=8 (SLTU) -> 0.
- Pipelining and reserved codes: apply a different op on each of 4 consecutive cycles (AND, OR, XOR, then op=13). Each result must appear exactly one cycle after its inputs, with op=13 giving 0.

Source files
------------

// File: rtl/riscv_alu_pkg.sv
// Shared constants for the RV32I execute-stage ALU: datapath width, opcode map
// and shifter control encoding.
package riscv_alu_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned OP_W   = 4;
   localparam int unsigned SHAMT_W = 5;

   localparam logic [OP_W-1:0] ALU_ADD    = 4'd0;
   localparam logic [OP_W-1:0] ALU_SUB    = 4'd1;
   localparam logic [OP_W-1:0] ALU_AND    = 4'd2;
   localparam logic [OP_W-1:0] ALU_OR     = 4'd3;
   localparam logic [OP_W-1:0] ALU_XOR    = 4'd4;
   localparam logic [OP_W-1:0] ALU_SLL    = 4'd5;
   localparam logic [OP_W-1:0] ALU_SRL    = 4'd6;
   localparam logic [OP_W-1:0] ALU_SLT    = 4'd7;
   localparam logic [OP_W-1:0] ALU_SLTU   = 4'd8;
   localparam logic [OP_W-1:0] ALU_PASS_B = 4'd9;
   localparam logic [OP_W-1:0] ALU_PASS_A = 4'd10;
   localparam logic [OP_W-1:0] ALU_SRA    = 4'd11;

   typedef enum logic [1:0] {
      SH_SLL = 2'd0,
      SH_SRL = 2'd1,
      SH_SRA = 2'd2
   } sh_type_e;

endpackage

// File: rtl/alu_shifter.sv
// Combinational barrel shifter for SLL/SRL/SRA; only a 5-bit shift amount is seen.
module alu_shifter
   import riscv_alu_pkg::*;
(
   input  logic [XLEN-1:0]    in1_i,
   input  logic [SHAMT_W-1:0] shamt_i,
   input  sh_type_e           sh_type_i,
   output logic [XLEN-1:0]    result_c
);

   always_comb begin
      result_c = '0;
      unique case (sh_type_i)
         SH_SLL:  result_c = in1_i << shamt_i;
         SH_SRL:  result_c = in1_i >> shamt_i;
         SH_SRA:  result_c = XLEN'($signed(in1_i) >>> shamt_i);
         default: result_c = '0;
      endcase
   end

endmodule

// File: rtl/riscv_alu.sv
// RV32I integer ALU: twelve operations selected by alu_op, result registered
// for the next pipeline stage; reserved or unknown opcodes produce zero.
module riscv_alu
   import riscv_alu_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [XLEN-1:0]   in1,
   input  logic [XLEN-1:0]   in2,
   input  logic [OP_W-1:0]   alu_op,
   output logic [XLEN-1:0]   alu_out
);

   logic [XLEN-1:0] alu_out_d;
   logic [XLEN-1:0] alu_out_q;
   logic [XLEN-1:0] shift_c;
   sh_type_e        sh_type_c;
   logic            slt_c;
   logic            sltu_c;

   // Only the shift opcodes care about this; other opcodes ignore the shifter.
   always_comb begin
      sh_type_c = SH_SLL;
      if (alu_op == ALU_SRL) begin
         sh_type_c = SH_SRL;
      end else if (alu_op == ALU_SRA) begin
         sh_type_c = SH_SRA;
      end
   end

   alu_shifter u_shifter (
      .in1_i     (in1),
      .shamt_i   (in2[SHAMT_W-1:0]),
      .sh_type_i (sh_type_c),
      .result_c  (shift_c)
   );

   assign slt_c  = $signed(in1) < $signed(in2);
   assign sltu_c = in1 < in2;

   always_comb begin
      alu_out_d = '0;
      case (alu_op)
         ALU_ADD:    alu_out_d = in1 + in2;
         ALU_SUB:    alu_out_d = in1 - in2;
         ALU_AND:    alu_out_d = in1 & in2;
         ALU_OR:     alu_out_d = in1 | in2;
         ALU_XOR:    alu_out_d = in1 ^ in2;
         ALU_SLL:    alu_out_d = shift_c;
         ALU_SRL:    alu_out_d = shift_c;
         ALU_SLT:    alu_out_d = XLEN'(slt_c);
         ALU_SLTU:   alu_out_d = XLEN'(sltu_c);
         ALU_PASS_B: alu_out_d = in2;
         ALU_PASS_A: alu_out_d = in1;
         ALU_SRA:    alu_out_d = shift_c;
         default:    alu_out_d = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_out_q <= '0;
      end else begin
         alu_out_q <= alu_out_d;
      end
   end

   assign alu_out = alu_out_q;

endmodule

// File: tb/tb_riscv_alu.sv
// Directed bench for riscv_alu: reset behaviour, opcode results with
// hand-computed values, shift masking, wrap, compares and pipelining.
module tb_riscv_alu;

   logic        clk;
   logic        rst_n;
   logic [31:0] in1;
   logic [31:0] in2;
   logic [3:0]  alu_op;
   logic [31:0] alu_out;

   int checks = 0;
   int errors = 0;

   riscv_alu dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .in1     (in1),
      .in2     (in2),
      .alu_op  (alu_op),
      .alu_out (alu_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] exp);
      checks++;
      assert (alu_out === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, alu_out, exp);
      end
   endtask

   // Apply operands, clock once, then compare just after the edge.
   task automatic step(input string tag, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp);
      alu_op = op;
      in1    = a;
      in2    = b;
      @(posedge clk);
      #1;
      chk(tag, exp);
   endtask

   initial begin
      rst_n  = 1'b0;
      in1    = 32'h0;
      in2    = 32'h0;
      alu_op = 4'd0;
      #1;
      chk("reset_initial", 32'h0);

      // Release mid-cycle (t=7, between edges at 5 and 15).
      #6;
      rst_n = 1'b1;
      #1;
      chk("reset_release_hold", 32'h0);

      step("pass_a", 4'd10, 32'h12345678, 32'h0, 32'h12345678);

      // Asynchronous assert mid-cycle with a live result.
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_reset_clear", 32'h0);
      #2;
      rst_n = 1'b1;
      #1;
      chk("reset_deassert_no_edge", 32'h0);
      @(posedge clk);
      #1;
      chk("reset_deassert_first_edge", 32'h12345678);

      step("sra_neg", 4'd11, 32'hFFFFFFFE, 32'd14, 32'hFFFFFFFF);
      step("srl_neg", 4'd6,  32'hFFFFFFFE, 32'd14, 32'h0003FFFF);
      step("sll_mask", 4'd5, 32'h00000001, 32'h00000021, 32'h00000002);
      step("sra_shamt0", 4'd11, 32'h80000001, 32'h00000020, 32'h80000001);
      step("sra_31", 4'd11, 32'h80000000, 32'h0000001F, 32'hFFFFFFFF);
      step("srl_31", 4'd6, 32'h80000000, 32'h0000001F, 32'h00000001);
      step("add_wrap", 4'd0, 32'hFFFFFFFF, 32'h1, 32'h00000000);
      step("add_plain", 4'd0, 32'h00001000, 32'h00000234, 32'h00001234);
      step("sub_wrap", 4'd1, 32'h0, 32'h1, 32'hFFFFFFFF);
      step("slt_neg", 4'd7, 32'hFFFFFFFE, 32'd14, 32'h00000001);
      step("sltu_neg", 4'd8, 32'hFFFFFFFE, 32'd14, 32'h00000000);
      step("slt_pos_ge", 4'd7, 32'd14, 32'hFFFFFFFE, 32'h00000000);
      step("sltu_small", 4'd8, 32'd14, 32'hFFFFFFFE, 32'h00000001);
      step("pass_b", 4'd9, 32'hDEADBEEF, 32'hABCDE000, 32'hABCDE000);
      step("reserved15", 4'd15, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000);

      // Back-to-back ops; output must hold while the next inputs settle.
      step("pipe_and", 4'd2, 32'hF0F01234, 32'h0FF05678, 32'h00F01230);
      alu_op = 4'd3;
      #3;
      chk("pipe_and_hold", 32'h00F01230);
      @(posedge clk);
      #1;
      chk("pipe_or", 32'hFFF0567C);
      alu_op = 4'd4;
      #3;
      chk("pipe_or_hold", 32'hFFF0567C);
      @(posedge clk);
      #1;
      chk("pipe_xor", 32'hFF00444C);
      alu_op = 4'd13;
      #3;
      chk("pipe_xor_hold", 32'hFF00444C);
      @(posedge clk);
      #1;
      chk("pipe_reserved13", 32'h00000000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
